peaks_readout: RTL and testbench
================================

Name: peaks_readout

Overview:
- Downstream consumer of the peak finder. Captures each completed peak frame into a small FIFO: a time counter plus PEAKS (frequency, amplitude) pairs.
- Exposes the frames to the software driver through the 8-bit, 3-bit-address register port (writedata/write/chipselect/address/readdata) of the accelerator top level.
- Software pops frames one at a time, so the hardware never overwrites a frame that is being read.

Parameters:
- PEAKS, 6: peaks per frame.
- FREQ_WIDTH, 8: peak frequency bin width, ≤16.
- AMPL_WIDTH, 16: peak amplitude width, ≤16.
- TIME_WIDTH, 16: frame time counter width, ≤16.
- DEPTH, 8: FIFO depth in frames, power of 2, ≤32.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  one-cycle strobe: peak frame inputs are valid this cycle
- amplitudes_in  in  PEAKS×AMPL_WIDTH  peak amplitudes, index 0..PEAKS-1
- freqs_in  in  PEAKS×FREQ_WIDTH  peak frequency bins
- counter_in  in  TIME_WIDTH  frame time stamp
- chipselect  in  1  bus access select
- write  in  1  1 = write, 0 = read (qualified by chipselect)
- address  in  3  register address
- writedata  in  8  write data
- readdata  out  8  registered read data
- irq  out  1  high while the FIFO is non-empty

Behaviour:
- Reset (async, active-high): wr_ptr, rd_ptr, level, overflow, peak_sel, readdata and irq all go to 0. Stored frame contents are don't-care.
- Push: when valid_in=1 and level<DEPTH, the whole frame is written at wr_ptr in one cycle, wr_ptr increments (wraps mod DEPTH) and level increments.
- Push while full (level==DEPTH) and no pop in the same cycle: the frame is dropped, FIFO state is unchanged, and the overflow flag is set (sticky).
- Pop: a write to address 0 with writedata[0]=1 and level>0 increments rd_ptr (wraps) and decrements level.
  - Pop when empty: ignored, no state change.
- Push and pop in the same cycle: both are performed and level is unchanged. This holds when full, with no overflow set.
- Overflow clear: a write to address 0 with writedata[1]=1 clears overflow. Set takes priority over clear in the same cycle.
- irq = (level!=0), registered; it reflects the level from the previous cycle.
- Register map. Reads return the head frame (at rd_ptr); fields are zero-extended to 16 bits and read as lo/hi byte pairs.
  - 0 R: {overflow, empty, level[5:0]}. W: bit0 = pop, bit1 = clear overflow.
  - 1 R/W: peak_sel[7:0].
  - 2 R: freq[peak_sel][7:0]; 3 R: freq[peak_sel][15:8].
  - 4 R: ampl[peak_sel][7:0]; 5 R: ampl[peak_sel][15:8].
  - 6 R: counter[7:0]; 7 R: counter[15:8].
  - Writes to addresses 2–7 are ignored.
- Reads of addresses 2–7 return 0 when the FIFO is empty. Reads of addresses 2–5 return 0 when peak_sel≥PEAKS.
- Read latency: readdata is updated on the clock edge following the chipselect & !write cycle and holds its value otherwise.
  - A read in the same cycle as a push or pop samples pre-edge state.
- Reset asserted mid-frame or mid-read: everything returns to reset values immediately; a frame being captured is lost.

Decomposition:
- Package peaks_pkg holds:
  - PEAKS, FREQ_WIDTH, AMPL_WIDTH, TIME_WIDTH.
  - A peak_frame_t packed struct {counter; freqs[PEAKS]; ampls[PEAKS]}.
  - Register address constants ADDR_STATUS, ADDR_SEL, ADDR_FREQ_LO … ADDR_TIME_HI.
- One sub-module: peak_frame_fifo. It is a generic flop-based FIFO of peak_frame_t with push, pop, full, empty, level and head output.
- peaks_readout wraps peak_frame_fifo and adds the register decode, the overflow flag and irq.

Test Plan:
- Reset, then read addr 0 -> readdata=0x40 (empty=1, level=0); irq=0; reads of addr 2–7 -> 0.
- One frame with counter=0x1234, freqs[2]=0x5A, ampls[2]=0xBEEF; write addr1=2; read addr 2,3,4,5,6,7 -> 0x5A, 0x00, 0xEF, 0xBE, 0x34, 0x12; status=0x01; irq=1 one cycle after push.
- Push 9 frames (DEPTH=8) with counters 0..8 -> status=0x88. Pop 8 times, reading addr 6 before each pop -> 0..7 in order; after the last pop status=0xC0. Write 0x02 to addr 0 -> status=0x40.
- FIFO full, valid_in and pop-write in the same cycle -> level stays 8, overflow stays 0, newest frame present at the tail.
- Pop on empty -> status stays 0x40. peak_sel=7 with a frame present -> addr 2–5 read 0.
- Assert reset after 3 pushes mid-read -> readdata=0 and irq=0 immediately; after release, status=0x40.

Source files
------------

// File: rtl/peaks_pkg.sv
// Shared types and constants for the peak readout block: frame layout and
// register addresses of the 8-bit software port.
package peaks_pkg;

  localparam int PEAKS      = 6;
  localparam int FREQ_WIDTH = 8;
  localparam int AMPL_WIDTH = 16;
  localparam int TIME_WIDTH = 16;

  typedef struct packed {
    logic [TIME_WIDTH-1:0]             counter;
    logic [PEAKS-1:0][FREQ_WIDTH-1:0]  freqs;
    logic [PEAKS-1:0][AMPL_WIDTH-1:0]  ampls;
  } peak_frame_t;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_SEL     = 3'd1;
  localparam logic [2:0] ADDR_FREQ_LO = 3'd2;
  localparam logic [2:0] ADDR_FREQ_HI = 3'd3;
  localparam logic [2:0] ADDR_AMPL_LO = 3'd4;
  localparam logic [2:0] ADDR_AMPL_HI = 3'd5;
  localparam logic [2:0] ADDR_TIME_LO = 3'd6;
  localparam logic [2:0] ADDR_TIME_HI = 3'd7;

endpackage

// File: rtl/peak_frame_fifo.sv
// Flop-based FIFO of whole peak frames. A push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module peak_frame_fifo
  import peaks_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  peak_frame_t              din,
  output peak_frame_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  peak_frame_t       mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/peaks_readout.sv
// Captures peak frames into a FIFO and exposes the head frame to software
// through an 8-bit register port with pop, sticky overflow and level irq.
module peaks_readout
  import peaks_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0] amplitudes_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
  input  logic [TIME_WIDTH-1:0]       counter_in,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [2:0]                  address,
  input  logic [7:0]                  writedata,
  output logic [7:0]                  readdata,
  output logic                        irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  peak_frame_t            frame_in;
  peak_frame_t            head;
  logic                   full;
  logic                   empty;
  logic [LW-1:0]          level;
  logic                   overflow;
  logic [7:0]             peak_sel;
  logic                   wr_en;
  logic                   rd_en;
  logic                   pop_req;
  logic                   clr_ovf;
  logic                   ovf_set;
  logic [FREQ_WIDTH-1:0]  freq_sel;
  logic [AMPL_WIDTH-1:0]  ampl_sel;
  logic [15:0]            freq16;
  logic [15:0]            ampl16;
  logic [15:0]            time16;
  logic                   sel_ok;
  logic [7:0]             rdata;

  always_comb begin
    frame_in         = '0;
    frame_in.counter = counter_in;
    for (int i = 0; i < PEAKS; i++) begin
      frame_in.freqs[i] = freqs_in[i*FREQ_WIDTH +: FREQ_WIDTH];
      frame_in.ampls[i] = amplitudes_in[i*AMPL_WIDTH +: AMPL_WIDTH];
    end
  end

  assign wr_en   = chipselect && write;
  assign rd_en   = chipselect && !write;
  assign pop_req = wr_en && (address == ADDR_STATUS) && writedata[0];
  assign clr_ovf = wr_en && (address == ADDR_STATUS) && writedata[1];
  // A full FIFO can still take a frame if software pops in the same cycle.
  assign ovf_set = valid_in && full && !pop_req;

  peak_frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (valid_in),
    .pop   (pop_req),
    .din   (frame_in),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    freq_sel = '0;
    ampl_sel = '0;
    for (int i = 0; i < PEAKS; i++) begin
      if (peak_sel == 8'(i)) begin
        freq_sel = head.freqs[i];
        ampl_sel = head.ampls[i];
      end
    end
  end

  assign sel_ok = (peak_sel < 8'(PEAKS));
  assign freq16 = 16'(freq_sel);
  assign ampl16 = 16'(ampl_sel);
  assign time16 = 16'(head.counter);

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_STATUS:  rdata = {overflow, empty, 6'(level)};
      ADDR_SEL:     rdata = peak_sel;
      ADDR_FREQ_LO: if (!empty && sel_ok) rdata = freq16[7:0];
      ADDR_FREQ_HI: if (!empty && sel_ok) rdata = freq16[15:8];
      ADDR_AMPL_LO: if (!empty && sel_ok) rdata = ampl16[7:0];
      ADDR_AMPL_HI: if (!empty && sel_ok) rdata = ampl16[15:8];
      ADDR_TIME_LO: if (!empty) rdata = time16[7:0];
      ADDR_TIME_HI: if (!empty) rdata = time16[15:8];
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      peak_sel <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= (level != '0);
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (wr_en && (address == ADDR_SEL)) peak_sel <= writedata;
      if (rd_en) readdata <= rdata;
    end
  end

endmodule

// File: tb/tb_peaks_readout.sv
// Directed self-checking bench for peaks_readout: register reads, FIFO
// ordering, overflow, simultaneous push/pop and asynchronous reset.
module tb_peaks_readout;
  import peaks_pkg::*;

  logic                        clk;
  logic                        reset;
  logic                        valid_in;
  logic [PEAKS*AMPL_WIDTH-1:0] amplitudes_in;
  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in;
  logic [TIME_WIDTH-1:0]       counter_in;
  logic                        chipselect;
  logic                        write;
  logic [2:0]                  address;
  logic [7:0]                  writedata;
  logic [7:0]                  readdata;
  logic                        irq;

  int n_checks = 0;
  int n_fail   = 0;

  peaks_readout #(.DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .amplitudes_in (amplitudes_in),
    .freqs_in      (freqs_in),
    .counter_in    (counter_in),
    .chipselect    (chipselect),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_frame(input logic [15:0] cnt, input logic [7:0] f2, input logic [15:0] a2);
    counter_in = cnt;
    for (int i = 0; i < PEAKS; i++) begin
      freqs_in[i*FREQ_WIDTH +: FREQ_WIDTH]      = 8'h10 + 8'(i);
      amplitudes_in[i*AMPL_WIDTH +: AMPL_WIDTH] = 16'h1000 + 16'(i);
    end
    freqs_in[2*FREQ_WIDTH +: FREQ_WIDTH]      = f2;
    amplitudes_in[2*AMPL_WIDTH +: AMPL_WIDTH] = a2;
  endtask

  task automatic push_frame(input logic [15:0] cnt);
    @(negedge clk);
    set_frame(cnt, 8'h5A, 16'hBEEF);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = 8'h00;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b0; address = a;
    @(posedge clk);
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (readdata !== 8'h00) begin n_fail++; $display("FAIL reset_readdata: got %h expected 00", readdata); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL reset_status: got %h expected 40", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after: got %b expected 0", irq); end
    for (int a = 2; a < 8; a++) begin
      bus_read(3'(a), d);
      n_checks++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL empty_read addr%0d: got %h expected 00", a, d); end
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    logic [7:0] exp_b [8];
    exp_b[2] = 8'h5A; exp_b[3] = 8'h00; exp_b[4] = 8'hEF;
    exp_b[5] = 8'hBE; exp_b[6] = 8'h34; exp_b[7] = 8'h12;
    @(negedge clk);
    set_frame(16'h1234, 8'h5A, 16'hBEEF);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_push_edge: got %b expected 0", irq); end
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_push: got %b expected 1", irq); end
    bus_write(ADDR_SEL, 8'd2);
    bus_read(ADDR_SEL, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL peak_sel_read: got %h expected 02", d); end
    for (int a = 2; a < 8; a++) begin
      bus_read(3'(a), d);
      n_checks++;
      if (d !== exp_b[a]) begin n_fail++; $display("FAIL frame_read addr%0d: got %h expected %h", a, d, exp_b[a]); end
    end
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL single_status: got %h expected 01", d); end
    bus_write(ADDR_STATUS, 8'h01);
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL single_pop_status: got %h expected 40", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_frame(16'(i), 8'h5A, 16'hBEEF);
      valid_in = 1'b1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h88) begin n_fail++; $display("FAIL overflow_status: got %h expected 88", d); end
    for (int i = 0; i < 8; i++) begin
      bus_read(ADDR_TIME_LO, d);
      n_checks++;
      if (d !== 8'(i)) begin n_fail++; $display("FAIL fifo_order pop%0d: got %h expected %h", i, d, 8'(i)); end
      bus_write(ADDR_STATUS, 8'h01);
    end
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'hC0) begin n_fail++; $display("FAIL drained_status: got %h expected c0", d); end
    bus_write(ADDR_STATUS, 8'h02);
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL ovf_clear_status: got %h expected 40", d); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) push_frame(16'h0020 + 16'(i));
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h08) begin n_fail++; $display("FAIL full_status: got %h expected 08", d); end
    @(negedge clk);
    set_frame(16'h0099, 8'h5A, 16'hBEEF);
    valid_in = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = ADDR_STATUS; writedata = 8'h01;
    @(negedge clk);
    valid_in = 1'b0; chipselect = 1'b0; write = 1'b0; writedata = 8'h00;
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h08) begin n_fail++; $display("FAIL pushpop_full_status: got %h expected 08", d); end
    bus_read(ADDR_TIME_LO, d);
    n_checks++;
    if (d !== 8'h21) begin n_fail++; $display("FAIL pushpop_head: got %h expected 21", d); end
    repeat (7) bus_write(ADDR_STATUS, 8'h01);
    bus_read(ADDR_TIME_LO, d);
    n_checks++;
    if (d !== 8'h99) begin n_fail++; $display("FAIL pushpop_tail: got %h expected 99", d); end
    bus_write(ADDR_STATUS, 8'h01);
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL pushpop_drain: got %h expected 40", d); end
  endtask

  task automatic test_empty_and_sel();
    logic [7:0] d;
    bus_write(ADDR_STATUS, 8'h01);
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL empty_pop_status: got %h expected 40", d); end
    push_frame(16'hA55A);
    bus_write(ADDR_SEL, 8'd7);
    for (int a = 2; a < 6; a++) begin
      bus_read(3'(a), d);
      n_checks++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL sel_out_of_range addr%0d: got %h expected 00", a, d); end
    end
    bus_read(ADDR_TIME_HI, d);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL sel7_time_hi: got %h expected a5", d); end
    bus_write(ADDR_SEL, 8'd5);
    bus_read(ADDR_AMPL_LO, d);
    n_checks++;
    if (d !== 8'h05) begin n_fail++; $display("FAIL sel5_ampl_lo: got %h expected 05", d); end
    bus_read(ADDR_FREQ_LO, d);
    n_checks++;
    if (d !== 8'h15) begin n_fail++; $display("FAIL sel5_freq_lo: got %h expected 15", d); end
    bus_write(ADDR_STATUS, 8'h01);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    for (int i = 0; i < 3; i++) push_frame(16'h0070 + 16'(i));
    bus_write(ADDR_SEL, 8'd3);
    bus_read(ADDR_TIME_LO, d);
    n_checks++;
    if (d !== 8'h70) begin n_fail++; $display("FAIL premid_read: got %h expected 70", d); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL premid_irq: got %b expected 1", irq); end
    @(negedge clk);
    chipselect = 1'b1; write = 1'b0; address = ADDR_TIME_LO;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (readdata !== 8'h00) begin n_fail++; $display("FAIL midreset_readdata: got %h expected 00", readdata); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    chipselect = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL postreset_status: got %h expected 40", d); end
    bus_read(ADDR_SEL, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL postreset_sel: got %h expected 00", d); end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; amplitudes_in = '0; freqs_in = '0;
    counter_in = '0; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_push_pop_full();
    test_empty_and_sel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
